harmonica_envelope: RTL

Attack/sustain/release amplitude envelope between `harmonica_memory` and `pwm_generator` in `harmonica_top`. Takes the raw `play` button and the 8-bit offset-binary sample from memory, and ramps a gain up while `play` is held and down after release. Drives the scaled sample into the PWM stage, so notes fade in and out instead of clicking. Also reports when a note is still sounding, so the top level can keep the address counter running through the release tail.

---
 rtl/harmonica_pkg.sv | 15 +
 rtl/play_debouncer.sv | 55 +++++
 rtl/harmonica_envelope.sv | 135 +++++++++++++
 3 files changed

// File: rtl/harmonica_pkg.sv
// Shared types and constants for the harmonica audio path.
package harmonica_pkg;

    localparam int SAMPLE_W = 8;
    localparam int GAIN_MAX = 256;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_t;

endpackage

// File: rtl/play_debouncer.sv
// Two-flop synchronizer for the play button, with an optional stability
// filter compiled in when HARMONICA_ENV_DEBOUNCE_EN is defined.
module play_debouncer
    import harmonica_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic play,
    output logic play_level
);

    logic sync_a;
    logic play_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            play_s <= 1'b0;
        end else begin
            sync_a <= play;
            play_s <= sync_a;
        end
    end

`ifdef HARMONICA_ENV_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] stable_cnt;
    logic             level;

    // The level flips only after play_s has disagreed with it for a full run.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (play_s != level) begin
            if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= play_s;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign play_level = level;
`else
    assign play_level = play_s;
`endif

endmodule

// File: rtl/harmonica_envelope.sv
// Attack/sustain/release gain envelope applied to offset-binary samples.
// Optional play debounce is enabled by defining HARMONICA_ENV_DEBOUNCE_EN.
module harmonica_envelope
    import harmonica_pkg::*;
#(
    parameter int TICK_DIV        = 4096,
    parameter int ATTACK_STEP     = 8,
    parameter int RELEASE_STEP    = 4,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                env_active
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [8:0] GAIN_FULL = 9'(GAIN_MAX);
    localparam logic [9:0] A_STEP    = 10'(ATTACK_STEP);
    localparam logic [8:0] R_STEP    = 9'(RELEASE_STEP);

    logic              play_level;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    env_state_t        state;
    env_state_t        state_next;
    logic [8:0]        gain;
    logic [8:0]        gain_next;
    logic [9:0]        attack_sum;

    play_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_play (
        .clk       (clk),
        .rst       (rst),
        .play      (play),
        .play_level(play_level)
    );

    // Free-running prescaler; never re-phased by state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gain  <= '0;
        end else begin
            state <= state_next;
            gain  <= gain_next;
        end
    end

    // A change of play level always wins over a tick; the gain holds that cycle.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        attack_sum = {1'b0, gain} + A_STEP;
        case (state)
            IDLE: begin
                gain_next = '0;
                if (play_level) begin
                    state_next = ATTACK;
                end
            end
            ATTACK: begin
                if (!play_level) begin
                    state_next = RELEASE;
                end else if (tick) begin
                    if (attack_sum >= {1'b0, GAIN_FULL}) begin
                        gain_next  = GAIN_FULL;
                        state_next = SUSTAIN;
                    end else begin
                        gain_next = attack_sum[8:0];
                    end
                end
            end
            SUSTAIN: begin
                gain_next = GAIN_FULL;
                if (!play_level) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (play_level) begin
                    state_next = ATTACK;
                end else if (tick) begin
                    if (gain <= R_STEP) begin
                        gain_next  = '0;
                        state_next = IDLE;
                    end else begin
                        gain_next = gain - R_STEP;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gain_next  = '0;
            end
        endcase
    end

    logic signed [17:0] centered;
    logic signed [17:0] gain_ext;
    logic signed [17:0] product;
    logic [SAMPLE_W-1:0] sample_next;

    // Floor of the shifted product keeps the result inside 0..255 without clamping.
    assign centered    = $signed({10'b0, sample_in}) - 18'sd128;
    assign gain_ext    = $signed({9'b0, gain});
    assign product     = centered * gain_ext;
    assign sample_next = 8'(product >>> 8) + MIDSCALE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out <= MIDSCALE;
        end else begin
            sample_out <= sample_next;
        end
    end

    assign env_active = (state != IDLE);

endmodule
